// File: rtl/mmio_lsu_controller.sv
// Load/store unit with lane alignment, misalignment reject and MMIO registers.
// Define MMIO_CYCLE_COUNTER_EN to map a free-running cycle counter after the input port.
module mmio_lsu_controller #(
  parameter logic [31:0] IO_BASE     = 32'h100,
  parameter int          NUM_OUT     = 2,
  parameter int          OUT_W       = 4,
  parameter int          IN_W        = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [2:0]               funct3_i,
  input  logic [31:0]              addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o,
  output logic                     done_o,
  output logic                     misaligned_o,
  output logic                     mem_req_o,
  output logic [3:0]               mem_be_o,
  output logic [31:0]              mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  input  logic [31:0]              mem_rdata_i,
  input  logic                     mem_ack_i,
  input  logic [IN_W-1:0]          gpio_in_i,
  output logic [NUM_OUT*OUT_W-1:0] gpio_out_o
);

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

`ifdef MMIO_CYCLE_COUNTER_EN
  localparam int IO_LAST = NUM_OUT + 1;
`else
  localparam int IO_LAST = NUM_OUT;
`endif

  state_t state, state_nx;

  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;
  logic        mis_q;
  logic [31:0] rdata_q;

  logic [NUM_OUT-1:0][OUT_W-1:0]   out_q;
  logic [SYNC_STAGES-1:0][IN_W-1:0] sync_q;
  logic [IN_W-1:0]                  in_sync;

  logic [29:0] io_off;
  logic        io_hit;
  logic        misal;
  logic        accept;
  logic [3:0]  st_be;
  logic [31:0] st_wd;
  logic [31:0] io_rword;
  logic [31:0] io_wword;

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [31:0] cnt_q;
`endif

  function automatic logic [3:0] be_of(input logic [2:0] f3,
                                       input logic [1:0] a);
    logic [3:0] be;
    unique case (1'b1)
      f3[1]:   be = 4'hF;
      f3[0]:   be = 4'b0011 << a;
      default: be = 4'b0001 << a;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wd_of(input logic [2:0]  f3,
                                        input logic [31:0] wd);
    logic [31:0] d;
    unique case (1'b1)
      f3[1]:   d = wd;
      f3[0]:   d = {2{wd[15:0]}};
      default: d = {4{wd[7:0]}};
    endcase
    return d;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [2:0]  f3,
                                          input logic [1:0]  a);
    logic [31:0] sh;
    logic [31:0] r;
    sh = w >> {a, 3'b000};
    unique case (1'b1)
      f3[1]:   r = w;
      f3[0]:   r = f3[2] ? {16'h0, sh[15:0]}
                         : {{16{sh[15]}}, sh[15:0]};
      default: r = f3[2] ? {24'h0, sh[7:0]}
                         : {{24{sh[7]}}, sh[7:0]};
    endcase
    return r;
  endfunction

  assign accept = (state == IDLE) && req_i;
  assign io_off = addr_i[31:2] - IO_BASE[31:2];
  assign io_hit = (addr_i[31:2] >= IO_BASE[31:2])
               && (io_off <= 30'(IO_LAST));
  assign misal  = funct3_i[1] ? (|addr_i[1:0])
                              : (funct3_i[0] & addr_i[0]);
  assign st_be  = be_of(funct3_i, addr_i[1:0]);
  assign st_wd  = wd_of(funct3_i, wdata_i);
  assign in_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    io_rword = 32'h0;
    for (int k = 0; k < NUM_OUT; k++)
      if (io_off == 30'(k)) io_rword = 32'(out_q[k]);
    if (io_off == 30'(NUM_OUT)) io_rword = 32'(in_sync);
`ifdef MMIO_CYCLE_COUNTER_EN
    if (io_off == 30'(NUM_OUT + 1)) io_rword = cnt_q;
`endif
  end

  // Byte-lane merge keeps unwritten lanes of the register's current value
  always_comb begin
    io_wword = io_rword;
    for (int b = 0; b < 4; b++)
      if (st_be[b]) io_wword[8*b +: 8] = st_wd[8*b +: 8];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req_i) state_nx = (misal || io_hit) ? RESP : MEM;
      MEM:  if (mem_ack_i) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    done_o       = (state == RESP);
    misaligned_o = (state == RESP) && mis_q;
    mem_req_o    = (state == MEM) && !rst_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wd_q    <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      out_q   <= '0;
    end else begin
      if (accept) begin
        addr_q <= addr_i;
        f3_q   <= funct3_i;
        we_q   <= we_i;
        be_q   <= we_i ? st_be : 4'h0;
        wd_q   <= st_wd;
        mis_q  <= misal;
        if (!misal && io_hit) begin
          if (we_i) begin
            for (int k = 0; k < NUM_OUT; k++)
              if (io_off == 30'(k)) out_q[k] <= io_wword[OUT_W-1:0];
          end else begin
            rdata_q <= extract(io_rword, funct3_i, addr_i[1:0]);
          end
        end
      end
      if (state == MEM && mem_ack_i && !we_q)
        rdata_q <= extract(mem_rdata_i, f3_q, addr_q[1:0]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in_i};
  end

`ifdef MMIO_CYCLE_COUNTER_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= '0;
    else if (accept && !misal && io_hit && we_i
             && io_off == 30'(NUM_OUT + 1))
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + 32'd1;
  end
`endif

  assign rdata_o     = rdata_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = {addr_q[31:2], 2'b00};
  assign mem_wdata_o = wd_q;
  assign gpio_out_o  = out_q;

endmodule

// File: tb/tb_mmio_lsu_controller.sv
// Directed scoreboard bench for mmio_lsu_controller (default build).
module tb_mmio_lsu_controller;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        misaligned_o;
  logic        mem_req_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;
  logic [3:0]  gpio_in_i = '0;
  logic [7:0]  gpio_out_o;

  mmio_lsu_controller dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .done_o(done_o),
    .misaligned_o(misaligned_o), .mem_req_o(mem_req_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .gpio_in_i(gpio_in_i),
    .gpio_out_o(gpio_out_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  cap_be;
  logic [31:0] cap_addr;
  logic [31:0] cap_wd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge with the DUT idle
  task automatic access(input string tag, input logic we,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] mrd,
                        input int ack_dly, input int exp_lat,
                        input int exp_req, input logic [31:0] exp_rd,
                        input logic exp_mis);
    int   lat;
    int   reqc;
    bit   got;
    exp_t e;
    req_i = 1'b1; we_i = we; funct3_i = f3;
    addr_i = addr; wdata_i = wd;
    sb.push_back('{rd: exp_rd, mis: exp_mis});
    @(posedge clk_i); #1;
    req_i = 1'b0;
    lat = 0; reqc = 0; got = 1'b0;
    while (!got && lat < 20) begin
      lat++;
      mem_ack_i = 1'b0;
      if (mem_req_o) begin
        reqc++;
        if (reqc == 1) begin
          cap_be = mem_be_o; cap_addr = mem_addr_o; cap_wd = mem_wdata_o;
        end
        mem_rdata_i = mrd;
        mem_ack_i = (reqc == ack_dly + 1);
      end
      if (done_o) begin
        got = 1'b1;
        e = sb.pop_front();
        chk({tag, "_rdata"}, rdata_o, e.rd);
        chk({tag, "_mis"}, 32'(misaligned_o), 32'(e.mis));
      end else begin
        @(posedge clk_i); #1;
      end
    end
    mem_ack_i = 1'b0;
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_req_cycles"}, reqc, exp_req);
    @(posedge clk_i); #1;
    chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    int seen;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_memreq", 32'(mem_req_o), 32'd0);
    chk("rst_gpio", 32'(gpio_out_o), 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    access("sb", 1'b1, 3'b000, 32'h2, 32'hA5, 32'h0, 0, 2, 1,
           32'h0, 1'b0);
    chk("sb_be", 32'(cap_be), 32'h4);
    chk("sb_wd_lane", 32'(cap_wd[23:16]), 32'hA5);
    chk("sb_addr", cap_addr, 32'h0);

    access("lb", 1'b0, 3'b000, 32'h3, 32'h0, 32'h80FF_0000, 3, 5, 4,
           32'hFFFF_FF80, 1'b0);
    chk("lb_be", 32'(cap_be), 32'h0);
    access("lbu", 1'b0, 3'b100, 32'h3, 32'h0, 32'h80FF_0000, 0, 2, 1,
           32'h0000_0080, 1'b0);

    access("io_sw0", 1'b1, 3'b010, 32'h100, 32'h7, 32'h0, 0, 1, 0,
           32'h80, 1'b0);
    access("io_sw1", 1'b1, 3'b010, 32'h104, 32'hC, 32'h0, 0, 1, 0,
           32'h80, 1'b0);
    chk("gpio_c7", 32'(gpio_out_o), 32'hC7);
    access("io_lw1", 1'b0, 3'b010, 32'h104, 32'h0, 32'h0, 0, 1, 0,
           32'hC, 1'b0);
    access("io_sb0", 1'b1, 3'b000, 32'h100, 32'h3, 32'h0, 0, 1, 0,
           32'hC, 1'b0);
    chk("gpio_c3", 32'(gpio_out_o), 32'hC3);
    access("io_lb1", 1'b0, 3'b000, 32'h104, 32'h0, 32'h0, 0, 1, 0,
           32'hC, 1'b0);

    gpio_in_i = 4'h9;
    repeat (3) @(posedge clk_i);
    #1;
    access("io_lw_in", 1'b0, 3'b010, 32'h108, 32'h0, 32'h0, 0, 1, 0,
           32'h9, 1'b0);
    access("io_sw_in", 1'b1, 3'b010, 32'h108, 32'hF, 32'h0, 0, 1, 0,
           32'h9, 1'b0);
    chk("gpio_in_store", 32'(gpio_out_o), 32'hC3);

    access("mis_lh", 1'b0, 3'b001, 32'h201, 32'h0, 32'h0, 0, 1, 0,
           32'h9, 1'b1);
    access("mis_sw", 1'b1, 3'b010, 32'h102, 32'h5, 32'h0, 0, 1, 0,
           32'h9, 1'b1);
    chk("mis_gpio", 32'(gpio_out_o), 32'hC3);

    access("past_io", 1'b0, 3'b010, 32'h10C, 32'h0, 32'h1234_5678,
           1, 3, 2, 32'h1234_5678, 1'b0);
    access("lh_hi", 1'b0, 3'b001, 32'h2, 32'h0, 32'h8001_7FFF, 0, 2, 1,
           32'hFFFF_8001, 1'b0);

    // Abandon an access mid-flight with an asynchronous reset
    req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010;
    addr_i = 32'h40;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(posedge clk_i); #1;
    chk("abort_req_hi", 32'(mem_req_o), 32'd1);
    #3 rst_i = 1'b1;
    #1;
    chk("abort_req_lo", 32'(mem_req_o), 32'd0);
    chk("abort_gpio", 32'(gpio_out_o), 32'h0);
    seen = 0;
    repeat (3) begin
      @(posedge clk_i); #1;
      if (done_o) seen++;
    end
    rst_i = 1'b0;
    repeat (2) begin
      @(posedge clk_i); #1;
      if (done_o) seen++;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_rdata", rdata_o, 32'h0);

    access("post_rst", 1'b0, 3'b010, 32'h44, 32'h0, 32'hDEAD_BEEF,
           0, 2, 1, 32'hDEAD_BEEF, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
